// File: rtl/gpio_sel_regs_if.sv
// Wishbone classic slave bundle for the GPIO design-select register bank.
// Signal names keep the Wishbone _i/_o suffixes as seen from the slave side.
interface gpio_sel_regs_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpio_sel_regs.sv
// Shadowed per-pin design-select registers for 38 GPIO pins, committed to the output mux as a whole.
// Optional macro GPIO_SEL_RANGE_CHECK_EN rejects nibbles >= NUM_DESIGNS and adds a sticky RANGE_ERR flag.
module gpio_sel_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_DESIGNS = 13
) (
  input  logic           clk,
  input  logic           nrst,
  gpio_sel_regs_if.slave wb,
  output logic [31:0]    pin_0to7_sel,
  output logic [31:0]    pin_8to15_sel,
  output logic [31:0]    pin_16to23_sel,
  output logic [31:0]    pin_24to31_sel,
  output logic [23:0]    pin_32to37_sel
);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] shadow_q [5];
  logic [31:0] active_q [5];
  logic        auto_q;
  logic        pending_q;
  logic        range_err_q;
  logic [31:0] dat_q;

  logic        req;
  logic        in_window;
  logic [2:0]  idx;
  logic        wr_sel;
  logic        wr_ctrl;
  logic        wr_status;
  logic [31:0] old_val;
  logic [31:0] merged;
  logic        range_hit;
  logic [31:0] rdata;
  logic [3:0]  nib;

  assign req       = (state_q == IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign in_window = (wb.wb_adr_i[31:5] == BASE_ADDR[31:5]);
  assign idx       = wb.wb_adr_i[4:2];
  assign wr_sel    = req && wb.wb_we_i && in_window && (idx < 3'd5);
  assign wr_ctrl   = req && wb.wb_we_i && in_window && (idx == 3'd5) && wb.wb_sel_i[0];
  assign wr_status = req && wb.wb_we_i && in_window && (idx == 3'd6) && wb.wb_sel_i[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb.wb_cyc_i && wb.wb_stb_i) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    case (idx)
      3'd0:    old_val = shadow_q[0];
      3'd1:    old_val = shadow_q[1];
      3'd2:    old_val = shadow_q[2];
      3'd3:    old_val = shadow_q[3];
      3'd4:    old_val = shadow_q[4];
      default: old_val = '0;
    endcase
  end

`ifdef GPIO_SEL_RANGE_CHECK_EN
  localparam logic [4:0] NUM_DESIGNS_W = 5'(NUM_DESIGNS);

  // Out-of-range nibbles keep their old value; in-range ones in the same write still land.
  always_comb begin
    merged    = old_val;
    range_hit = 1'b0;
    nib       = '0;
    for (int n = 0; n < 8; n++) begin
      if (wb.wb_sel_i[n >> 1]) begin
        nib = wb.wb_dat_i[4*n +: 4];
        if ({1'b0, nib} >= NUM_DESIGNS_W) range_hit = 1'b1;
        else                              merged[4*n +: 4] = nib;
      end
    end
    if (idx == 3'd4) merged[31:24] = 8'h00;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                              range_err_q <= 1'b0;
    else if (wr_sel && range_hit)           range_err_q <= 1'b1;
    else if (wr_status && wb.wb_dat_i[1])   range_err_q <= 1'b0;
  end
`else
  always_comb begin
    merged    = old_val;
    range_hit = 1'b0;
    nib       = '0;
    for (int n = 0; n < 8; n++) begin
      if (wb.wb_sel_i[n >> 1]) begin
        nib = wb.wb_dat_i[4*n +: 4];
        merged[4*n +: 4] = nib;
      end
    end
    if (idx == 3'd4) merged[31:24] = 8'h00;
  end

  assign range_err_q = 1'b0;

  logic [31:0] unused_no_range;
  assign unused_no_range = {NUM_DESIGNS[29:0], wr_status, range_hit};
`endif

  always_comb begin
    rdata = '0;
    if (in_window) begin
      case (idx)
        3'd0:    rdata = shadow_q[0];
        3'd1:    rdata = shadow_q[1];
        3'd2:    rdata = shadow_q[2];
        3'd3:    rdata = shadow_q[3];
        3'd4:    rdata = {8'h00, shadow_q[4][23:0]};
        3'd5:    rdata = {30'd0, auto_q, 1'b0};
        3'd6:    rdata = {30'd0, range_err_q, pending_q};
        default: rdata = '0;
      endcase
    end
  end

  // All register effects happen on the IDLE->ACK edge, so a commit is visible in the ACK cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      auto_q    <= 1'b0;
      pending_q <= 1'b0;
      dat_q     <= '0;
    end else begin
      dat_q <= '0;
      if (req && !wb.wb_we_i) dat_q <= rdata;
      if (wr_sel) begin
        for (int i = 0; i < 5; i++) begin
          if (idx == 3'(i)) begin
            shadow_q[i] <= merged;
            if (auto_q) active_q[i] <= merged;
          end
        end
        if (!auto_q) pending_q <= 1'b1;
      end
      if (wr_ctrl) begin
        auto_q <= wb.wb_dat_i[1];
        if (wb.wb_dat_i[0]) begin
          for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
          pending_q <= 1'b0;
        end
      end
    end
  end

  assign wb.wb_ack_o    = (state_q == ACK);
  assign wb.wb_dat_o    = dat_q;
  assign pin_0to7_sel   = active_q[0];
  assign pin_8to15_sel  = active_q[1];
  assign pin_16to23_sel = active_q[2];
  assign pin_24to31_sel = active_q[3];
  assign pin_32to37_sel = active_q[4][23:0];

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], active_q[4][31:24], shadow_q[4][31:24]};

endmodule
